// File: rtl/icache_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;

  function automatic int ic_tag_bits(input int index_bits, input int line_words_log);
    return 32 - index_bits - line_words_log - 2;
  endfunction

  localparam int ICACHE_INDEX_BITS     = 6;
  localparam int ICACHE_LINE_WORDS_LOG = 2;
  localparam int ICACHE_TAG_BITS       = ic_tag_bits(ICACHE_INDEX_BITS, ICACHE_LINE_WORDS_LOG);

  typedef enum logic [1:0] {
    IC_IDLE    = 2'd0,
    IC_REFILL  = 2'd1,
    IC_RESPOND = 2'd2
  } ic_state_t;

endpackage

// File: rtl/icache_line_array.sv
// Valid bits, tag RAM and data RAM for the cache lines.
// Combinational read by index; only the valid bits are cleared by reset.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS     = ICACHE_INDEX_BITS,
  parameter int LINE_WORDS_LOG = ICACHE_LINE_WORDS_LOG,
  parameter int TAG_BITS       = ICACHE_TAG_BITS
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [INDEX_BITS-1:0]     rd_index,
  input  logic [LINE_WORDS_LOG-1:0] rd_offset,
  output logic                      rd_valid,
  output logic [TAG_BITS-1:0]       rd_tag,
  output logic [31:0]               rd_word,
  input  logic                      word_we,
  input  logic [INDEX_BITS-1:0]     wr_index,
  input  logic [LINE_WORDS_LOG-1:0] wr_offset,
  input  logic [31:0]               wr_data,
  input  logic                      tag_we,
  input  logic [TAG_BITS-1:0]       wr_tag
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = LINES << LINE_WORDS_LOG;

  logic [LINES-1:0]    valid_reg;
  logic [TAG_BITS-1:0] tag_mem [LINES];
  logic [31:0]         data_mem [WORDS];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_reg <= '0;
    end else if (tag_we) begin
      valid_reg[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (word_we) begin
      data_mem[{wr_index, wr_offset}] <= wr_data;
    end
    if (tag_we) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

  assign rd_valid = valid_reg[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_word  = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, whole-line refill
// on a miss, exactly one have_result pulse per accepted fetch.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS     = ICACHE_INDEX_BITS,
  parameter int LINE_WORDS_LOG = ICACHE_LINE_WORDS_LOG
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        to_icache,
  input  logic [31:0] pc_to_icache,
  output logic        have_result,
  output logic [31:0] inst_from_icache,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
);

  localparam int IDX_LSB  = LINE_WORDS_LOG + 2;
  localparam int TAG_LSB  = IDX_LSB + INDEX_BITS;
  localparam int TAG_BITS = ic_tag_bits(INDEX_BITS, LINE_WORDS_LOG);
  localparam logic [31:0] LINE_MASK = ~((32'd1 << IDX_LSB) - 32'd1);

  ic_state_t                 state_reg;
  logic [31:2]               pc_reg;
  logic [LINE_WORDS_LOG-1:0] beat_reg;
  logic [31:0]               mem_addr_reg;
  logic                      mem_req_reg;
  logic                      have_result_reg;
  logic [31:0]               inst_reg;

  logic [INDEX_BITS-1:0]     rd_index;
  logic [LINE_WORDS_LOG-1:0] rd_offset;
  logic                      rd_valid;
  logic [TAG_BITS-1:0]       rd_tag;
  logic [31:0]               rd_word;
  logic                      hit;
  logic                      word_we;
  logic                      last_beat;
  logic                      tag_we;
  logic                      unused_pc_bits;

  assign unused_pc_bits = ^pc_to_icache[1:0];

  // Lookups use the live pc in IDLE; RESPOND reads back the latched request.
  always_comb begin
    rd_index  = pc_reg[IDX_LSB +: INDEX_BITS];
    rd_offset = pc_reg[2 +: LINE_WORDS_LOG];
    if (state_reg == IC_IDLE) begin
      rd_index  = pc_to_icache[IDX_LSB +: INDEX_BITS];
      rd_offset = pc_to_icache[2 +: LINE_WORDS_LOG];
    end
  end

  assign hit       = rd_valid && (rd_tag == pc_to_icache[TAG_LSB +: TAG_BITS]);
  assign word_we   = rdy_in && (state_reg == IC_REFILL) && mem_valid;
  assign last_beat = (beat_reg == {LINE_WORDS_LOG{1'b1}});
  assign tag_we    = word_we && last_beat;

  icache_line_array #(
    .INDEX_BITS     (INDEX_BITS),
    .LINE_WORDS_LOG (LINE_WORDS_LOG),
    .TAG_BITS       (TAG_BITS)
  ) u_lines (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rd_index  (rd_index),
    .rd_offset (rd_offset),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_word   (rd_word),
    .word_we   (word_we),
    .wr_index  (pc_reg[IDX_LSB +: INDEX_BITS]),
    .wr_offset (beat_reg),
    .wr_data   (mem_data),
    .tag_we    (tag_we),
    .wr_tag    (pc_reg[TAG_LSB +: TAG_BITS])
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg       <= IC_IDLE;
      pc_reg          <= '0;
      beat_reg        <= '0;
      mem_addr_reg    <= '0;
      mem_req_reg     <= 1'b0;
      have_result_reg <= 1'b0;
      inst_reg        <= '0;
    end else if (rdy_in) begin
      have_result_reg <= 1'b0;
      case (state_reg)
        IC_IDLE: begin
          if (to_icache) begin
            pc_reg <= pc_to_icache[31:2];
            if (hit) begin
              have_result_reg <= 1'b1;
              inst_reg        <= rd_word;
            end else begin
              state_reg    <= IC_REFILL;
              mem_req_reg  <= 1'b1;
              mem_addr_reg <= pc_to_icache & LINE_MASK;
              beat_reg     <= '0;
            end
          end
        end
        IC_REFILL: begin
          if (mem_valid) begin
            // The final beat leaves mem_addr on the last word of the line.
            if (last_beat) begin
              mem_req_reg <= 1'b0;
              beat_reg    <= '0;
              state_reg   <= IC_RESPOND;
            end else begin
              mem_addr_reg <= mem_addr_reg + 32'd4;
              beat_reg     <= beat_reg + 1'b1;
            end
          end
        end
        IC_RESPOND: begin
          have_result_reg <= 1'b1;
          inst_reg        <= rd_word;
          state_reg       <= IC_IDLE;
        end
        default: state_reg <= IC_IDLE;
      endcase
    end
  end

  assign have_result      = have_result_reg;
  assign inst_from_icache = inst_reg;
  assign mem_req          = mem_req_reg;
  assign mem_addr         = mem_addr_reg;

endmodule
